// File: rtl/weights_pkg.sv
// rtl/weights_pkg.sv - shared sizes, types, FSM states and table init for the weight replay/save slice
package weights_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ROWS       = 4;
  localparam int COLS       = 8;
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;

  typedef logic [DATA_WIDTH-1:0] weight_t;
  typedef logic [ROW_W-1:0]      row_t;
  typedef logic [COL_W-1:0]      col_t;

  localparam row_t LAST_ROW = row_t'(ROWS - 1);
  localparam col_t LAST_COL = col_t'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_VERIFY,
    ST_DONE
  } state_e;

  function automatic weight_t weight_init(input int r, input int c);
    return weight_t'(r * COLS + c + 1);
  endfunction
endpackage

// File: rtl/weights_ram.sv
// rtl/weights_ram.sv - save RAM: cleared on reset, written from the replay stream
// WEIGHTS_VERIFY_EN adds a registered read port used by the verify pass.
module weights_ram
  import weights_pkg::*;
(
`ifdef WEIGHTS_VERIFY_EN
  input  row_t    i_rd_row,
  input  col_t    i_rd_col,
  output weight_t o_rd_data,
`endif
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  input  row_t    i_row,
  input  col_t    i_col,
  input  weight_t i_data,
  input  logic    i_last,
  output logic    o_ready,
  output logic    o_full
);
  weight_t weights [ROWS][COLS];
  logic    r_full;

  assign o_ready = ~rst;
  assign o_full  = r_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          weights[r][c] <= '0;
        end
      end
      r_full <= 1'b0;
    end else if (i_valid) begin
      weights[i_row][i_col] <= i_data;
      if (i_last) begin
        r_full <= 1'b1;
      end
    end
  end

`ifdef WEIGHTS_VERIFY_EN
  weight_t r_rd_data;
  assign o_rd_data = r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= weights[i_rd_row][i_rd_col];
    end
  end
`endif
endmodule

// File: rtl/weights_replay.sv
// rtl/weights_replay.sv - constant weight table, transfer FSM and stream source
// WEIGHTS_VERIFY_EN adds a read-back compare pass between SEND and DONE.
module weights_replay
  import weights_pkg::*;
(
`ifdef WEIGHTS_VERIFY_EN
  output row_t    o_rd_row,
  output col_t    o_rd_col,
  input  weight_t i_rd_data,
`endif
  input  logic    clk,
  input  logic    rst,
  input  logic    i_ready,
  output logic    o_valid,
  output row_t    o_row,
  output col_t    o_col,
  output weight_t o_data,
  output logic    o_last,
  output logic    o_done,
  output logic    o_error
);
  weight_t weights [ROWS][COLS];

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      assign weights[gr][gc] = weight_init(gr, gc);
    end
  end

  state_e r_state;
  logic   r_valid;
  logic   r_done;
  row_t   r_row;
  col_t   r_col;
  logic   w_last;

  assign w_last  = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign o_valid = r_valid;
  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_data  = weights[r_row][r_col];
  assign o_last  = w_last;
  assign o_done  = r_done;

`ifdef WEIGHTS_VERIFY_EN
  logic r_error;
  logic r_issued;
  logic r_cmp_pend;
  row_t r_vrow;
  col_t r_vcol;
  row_t r_cmp_row;
  col_t r_cmp_col;
  logic w_mismatch;

  // Read data returns one cycle after the address, so compare against the delayed index.
  assign w_mismatch = r_cmp_pend && (i_rd_data != weights[r_cmp_row][r_cmp_col]);
  assign o_rd_row   = r_vrow;
  assign o_rd_col   = r_vcol;
  assign o_error    = r_error;
`else
  assign o_error    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
`ifdef WEIGHTS_VERIFY_EN
      r_error    <= 1'b0;
      r_issued   <= 1'b0;
      r_cmp_pend <= 1'b0;
      r_vrow     <= '0;
      r_vcol     <= '0;
      r_cmp_row  <= '0;
      r_cmp_col  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_SEND;
        ST_SEND: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (i_ready) begin
            if (w_last) begin
              r_valid <= 1'b0;
`ifdef WEIGHTS_VERIFY_EN
              r_state <= ST_VERIFY;
`else
              r_state <= ST_DONE;
`endif
            end else if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
`ifdef WEIGHTS_VERIFY_EN
        ST_VERIFY: begin
          if (w_mismatch) begin
            r_error <= 1'b1;
          end
          r_cmp_pend <= ~r_issued;
          r_cmp_row  <= r_vrow;
          r_cmp_col  <= r_vcol;
          if (!r_issued) begin
            if ((r_vrow == LAST_ROW) && (r_vcol == LAST_COL)) begin
              r_issued <= 1'b1;
            end else if (r_vcol == LAST_COL) begin
              r_vcol <= '0;
              r_vrow <= r_vrow + 1'b1;
            end else begin
              r_vcol <= r_vcol + 1'b1;
            end
          end else begin
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: r_done <= 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/weights_replay_and_save.sv
// rtl/weights_replay_and_save.sv - top: replay source streams its table into the save RAM after reset
// WEIGHTS_VERIFY_EN enables the read-back verify pass and the error flag.
module weights_replay_and_save
  import weights_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic done,
  output logic error
);
  logic    w_valid;
  logic    w_ready;
  row_t    w_row;
  col_t    w_col;
  weight_t w_data;
  logic    w_last;
  logic    w_rep_done;
  logic    w_ram_full;

`ifdef WEIGHTS_VERIFY_EN
  row_t    w_rd_row;
  col_t    w_rd_col;
  weight_t w_rd_data;
`endif

  weights_replay weights_replay_0 (
`ifdef WEIGHTS_VERIFY_EN
    .o_rd_row  (w_rd_row),
    .o_rd_col  (w_rd_col),
    .i_rd_data (w_rd_data),
`endif
    .clk       (clk),
    .rst       (rst),
    .i_ready   (w_ready),
    .o_valid   (w_valid),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_data    (w_data),
    .o_last    (w_last),
    .o_done    (w_rep_done),
    .o_error   (error)
  );

  weights_ram weights_ram_0 (
`ifdef WEIGHTS_VERIFY_EN
    .i_rd_row  (w_rd_row),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data),
`endif
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_valid),
    .i_row     (w_row),
    .i_col     (w_col),
    .i_data    (w_data),
    .i_last    (w_last),
    .o_ready   (w_ready),
    .o_full    (w_ram_full)
  );

  assign done = w_rep_done & w_ram_full;
endmodule

// File: tb/tb_weights_replay_and_save.sv
// tb/tb_weights_replay_and_save.sv - self-checking bench with a cycle-level model of the weight transfer
module tb_weights_replay_and_save;
  localparam int R = 4;
  localparam int C = 8;
  localparam int N = R * C;

  logic clk;
  logic rst;
  logic done;
  logic error;

  int n_checks;
  int n_fail;

  weights_replay_and_save dut (
    .clk   (clk),
    .rst   (rst),
    .done  (done),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_word(input int k);
    int v;
    v = k + 1;
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ram_cleared(input string tag);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        check($sformatf("%s ram[%0d][%0d]", tag, r, c),
              32'(dut.weights_ram_0.weights[r][c]), 32'h0);
      end
    end
    check({tag, " done"}, 32'(done), 32'h0);
    check({tag, " error"}, 32'(error), 32'h0);
  endtask

  // After edge n since release, words with k+2 <= n have landed; the rest are still zero.
  task automatic check_cycle(input string tag, input int n);
    logic [15:0] e;
    for (int k = 0; k < N; k++) begin
      e = (k + 2 <= n) ? exp_word(k) : 16'h0;
      check($sformatf("%s n=%0d ram[%0d][%0d]", tag, n, k / C, k % C),
            32'(dut.weights_ram_0.weights[k / C][k % C]), 32'(e));
    end
`ifdef WEIGHTS_VERIFY_EN
    if (n < 34) check($sformatf("%s n=%0d done early", tag, n), 32'(done), 32'h0);
    if (n >= 68) check($sformatf("%s n=%0d done late", tag, n), 32'(done), 32'h1);
`else
    check($sformatf("%s n=%0d done", tag, n), 32'(done), (n >= 34) ? 32'h1 : 32'h0);
`endif
    check($sformatf("%s n=%0d error", tag, n), 32'(error), 32'h0);
  endtask

  task automatic run_phase(input string tag, input int ncycles);
    for (int n = 0; n < ncycles; n++) begin
      @(posedge clk);
      #1;
      check_cycle(tag, n);
    end
  endtask

  task automatic reset_pulse(input string tag, input int ncycles);
    rst = 1'b1;
    for (int i = 0; i < ncycles; i++) begin
      @(posedge clk);
      #1;
    end
    check_ram_cleared(tag);
    rst = 1'b0;
  endtask

  initial begin
    int pulse_at;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    // Long reset: everything cleared, then one uninterrupted transfer.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 50) check_ram_cleared("mid_reset");
    end
    check_ram_cleared("end_reset");
    rst = 1'b0;
    run_phase("run1", 100);

    for (int i = 0; i < C; i++) begin
      check($sformatf("replay_table[0][%0d]", i),
            32'(dut.weights_replay_0.weights[0][i]), 32'(exp_word(i)));
      check($sformatf("ram_vs_replay[0][%0d]", i),
            32'(dut.weights_ram_0.weights[0][i]),
            32'(dut.weights_replay_0.weights[0][i]));
    end

    // One-cycle reset at cycle 10 of a transfer, then a clean restart.
    reset_pulse("pre_pulse10", 1);
    run_phase("pre10", 11);
    reset_pulse("pulse10", 1);
    run_phase("after10", 100);

    // Randomly placed reset pulses of random length.
    for (int t = 0; t < 3; t++) begin
      pulse_at = $urandom_range(0, 40);
      run_phase($sformatf("rnd%0d_pre", t), 0);
      reset_pulse($sformatf("rnd%0d_start", t), 1);
      run_phase($sformatf("rnd%0d_a", t), pulse_at + 1);
      reset_pulse($sformatf("rnd%0d_pulse", t), $urandom_range(1, 3));
      run_phase($sformatf("rnd%0d_b", t), 80);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
